// File: rtl/rf_write_arbiter.sv
// Single write-port owner for the register file: round-robin arbitration between
// two writeback requesters, plus a sequencer that zeroes registers 1..NREGS-1.
module rf_write_arbiter #(
  parameter int NREGS = 32,
  parameter int AW    = 6,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  input  logic          clear_req,
  output logic          busy,
  output logic          clear_done,
  output logic          addr_err,
  output logic [AW-1:0] rf_addressw,
  output logic [DW-1:0] rf_writeData,
  output logic          rf_writeEn
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          last_grant;
  logic          hs0, hs1;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_in_range;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and clear counter progression
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        cnt_nx = AW'(1);
        if (clear_req) begin
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt == LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: combinational readys, only in IDLE with no clear pending
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && state == IDLE && !clear_req) begin
      req0_ready = req0_valid && (!req1_valid || last_grant);
      req1_ready = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;

  always_comb begin
    sel_addr = hs1 ? req1_addr : req0_addr;
    sel_data = hs1 ? req1_data : req0_data;
  end

  // Widened compare so NREGS == 2**AW stays representable
  assign sel_in_range = (32'(sel_addr) < 32'(NREGS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= AW'(1);
    end else if (state_nx == CLEAR) begin
      cnt <= cnt_nx;
    end
  end

  // last_grant=1 means requester 1 won last, so requester 0 is favoured next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (hs0) begin
      last_grant <= 1'b0;
    end else if (hs1) begin
      last_grant <= 1'b1;
    end
  end

  // Registered write port: loaded with what the next cycle must present
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_writeEn   <= 1'b0;
      rf_addressw  <= '0;
      rf_writeData <= '0;
      busy         <= 1'b0;
      clear_done   <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      rf_writeEn <= 1'b0;
      clear_done <= 1'b0;
      addr_err   <= 1'b0;
      busy       <= (state_nx == CLEAR);
      if (state_nx == CLEAR) begin
        rf_writeEn   <= 1'b1;
        rf_addressw  <= cnt_nx;
        rf_writeData <= '0;
        clear_done   <= (cnt_nx == LAST);
      end else if (hs0 || hs1) begin
        rf_addressw  <= sel_addr;
        rf_writeData <= sel_data;
        rf_writeEn   <= (sel_addr != '0) && sel_in_range;
        addr_err     <= !sel_in_range;
      end
    end
  end

endmodule
